// File: rtl/adder64_seq_pkg.sv
// adder64_seq_pkg: shared constants and FSM state encoding for the sequential 64-bit adder
package adder64_seq_pkg;
    localparam int SLICE_W = 16;
    localparam int NSLICE  = 4;
    localparam int W       = SLICE_W * NSLICE;
    localparam int CNT_W   = $clog2(NSLICE);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/adder64_seq_ctrl_adder16.sv
// adder16: combinational 16-bit ripple slice
//   A, B : 16-bit operands, bit 1 = LSB
//   c0   : carry-in
//   S    : 16-bit sum
//   c16  : carry-out
module adder16 (
    input  logic [16:1] A,
    input  logic [16:1] B,
    input  logic        c0,
    output logic [16:1] S,
    output logic        c16
);
    assign {c16, S} = {1'b0, A} + {1'b0, B} + {16'd0, c0};
endmodule

// File: rtl/adder64_seq_ctrl.sv
// adder64_seq_ctrl: 64-bit adder time-multiplexing one adder16 over four cycles, LSB slice first
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   A, B, c0             : operands and carry-in, bit 1 = LSB
//   out_valid / out_ready: result handshake
//   S, c64               : sum and carry-out, held stable while out_valid
//   busy                 : FSM not in IDLE
//   ovf                  : signed overflow, present only when ADDER64_SEQ_OVF_EN is defined
module adder64_seq_ctrl
    import adder64_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:1]   A,
    input  logic [W:1]   B,
    input  logic         c0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:1]   S,
    output logic         c64,
    output logic         busy
`ifdef ADDER64_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       a_reg, b_reg, s_reg;
    logic               carry, c64_reg;
    logic [SLICE_W-1:0] a_sl, b_sl, sum_sl;
    logic               c16;
    logic               last;
    assign a_sl = a_reg[int'(cnt)*SLICE_W +: SLICE_W];
    assign b_sl = b_reg[int'(cnt)*SLICE_W +: SLICE_W];
    assign last = cnt == CNT_W'(NSLICE - 1);
    adder16 u_slice (
        .A   (a_sl),
        .B   (b_sl),
        .c0  (carry),
        .S   (sum_sl),
        .c16 (c16)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            s_reg   <= '0;
            carry   <= 1'b0;
            c64_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= A;
                    b_reg <= B;
                    carry <= c0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    s_reg[int'(cnt)*SLICE_W +: SLICE_W] <= sum_sl;
                    carry <= c16;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        c64_reg <= c16;
                        state   <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ADDER64_SEQ_OVF_EN
    logic ovf_reg;
    // carry into the MSB is recovered from the top bit's sum: a ^ b ^ s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_reg <= 1'b0;
        else if (state == RUN && last) ovf_reg <= a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ sum_sl[SLICE_W-1] ^ c16;
    end
    assign ovf = ovf_reg;
`endif
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign S         = s_reg;
    assign c64       = c64_reg;
endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// tb_adder64_seq_ctrl: directed vector table plus multi-cycle sequences and random ops for adder64_seq_ctrl
module tb_adder64_seq_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, out_ready = 0, c0 = 0;
    logic        in_ready, out_valid, c64, busy, ovf_w;
    logic [64:1] A = '0, B = '0, S;
    int          n_chk = 0, n_fail = 0, ops = 0, taken = 0;
    adder64_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c0        (c0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c64       (c64),
        .busy      (busy)
`ifdef ADDER64_SEQ_OVF_EN
        ,
        .ovf       (ovf_w)
`endif
    );
`ifndef ADDER64_SEQ_OVF_EN
    assign ovf_w = 1'b0;
`endif
    always #5 clk = ~clk;
    always @(posedge clk) if (rst_n && out_valid && out_ready) taken++;
    typedef struct {
        logic [63:0] a, b;
        logic        ci;
        logic [63:0] s;
        logic        c, o;
    } vec_t;
    vec_t tv[7];
    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Called at a negedge; returns at a negedge after the result has been taken.
    task automatic op(input logic [63:0] a, b, input logic ci, input int stall, input bit hold,
                      output logic [63:0] s, output logic c, output logic o, output int lat);
        int n;
        if (!hold) out_ready = 0;
        A = a; B = b; c0 = ci; in_valid = 1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0; A = {$urandom, $urandom}; B = {$urandom, $urandom}; c0 = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        s = S; c = c64; o = ovf_w;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1;
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_result", {c64, S}, {c, s});
        end
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        if (!hold) out_ready = 0;
        check("post_take_out_valid", out_valid, 0);
        check("post_take_in_ready", in_ready, 1);
        ops++;
    endtask
    initial begin
        logic [63:0] s, ra, rb;
        logic        c, o, rc;
        logic [64:0] ref_sum;
        int          lat;
        tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        tv[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        tv[2] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
        tv[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tv[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        tv[5] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1, 1'b0};
        tv[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", {c64, S}, 65'd0);
        rst_n = 1;
        @(negedge clk);
        foreach (tv[i]) begin
            op(tv[i].a, tv[i].b, tv[i].ci, 0, 0, s, c, o, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_sum", i), {c, s}, {tv[i].c, tv[i].s});
`ifdef ADDER64_SEQ_OVF_EN
            check($sformatf("vec%0d_ovf", i), o, tv[i].o);
`endif
        end
        // long stall with in_valid asserted, then confirm no phantom op follows
        op(64'h0, 64'h0, 1'b1, 10, 0, s, c, o, lat);
        check("stall_sum", {c, s}, 65'h1);
        repeat (3) @(negedge clk);
        check("no_phantom_out_valid", out_valid, 0);
        check("no_phantom_busy", busy, 0);
        // out_ready held high: DONE lasts exactly one cycle
        out_ready = 1;
        op(64'h1111_2222_3333_4444, 64'h1, 1'b0, 0, 1, s, c, o, lat);
        check("hold_ready_sum", {c, s}, {1'b0, 64'h1111_2222_3333_4445});
        out_ready = 0;
        // asynchronous abort two cycles into RUN
        A = 64'h1234_5678_9ABC_DEF0; B = 64'h1; c0 = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        check("abort_busy_before", busy, 1);
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_S", S, 64'h0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        op(64'h5, 64'h7, 1'b0, 0, 0, s, c, o, lat);
        check("post_abort_sum", {c, s}, 65'hC);
        check("post_abort_latency", lat, 4);
        for (int k = 0; k < 1000; k++) begin
            int stall;
            bit hold;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            if (k % 7 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            hold = ($urandom_range(0, 3) == 0);
            stall = hold ? 0 : $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op(ra, rb, rc, stall, hold, s, c, o, lat);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
            check("rand_sum", {c, s}, ref_sum);
            check("rand_latency", lat, 4);
`ifdef ADDER64_SEQ_OVF_EN
            check("rand_ovf", o, (ra[63] == rb[63]) && (ref_sum[63] != ra[63]));
`endif
        end
        out_ready = 0;
        repeat (2) @(negedge clk);
        check("taken_count", taken, ops);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
